// File: rtl/branch_resolve_queue_pkg.sv
// Shared widths and the in-flight branch entry layout for the branch resolve queue.
package branch_resolve_queue_pkg;

  localparam int unsigned BrqN     = 7;
  localparam int unsigned BrqDepth = 8;

  typedef struct packed {
    logic [BrqN-1:0] pc;
    logic            taken;
    logic [BrqN-1:0] history;
  } brq_entry_t;

endpackage

// File: rtl/branch_resolve_queue.sv
// In-order queue of predicted branches; resolves pop the head, emit a registered
// training pulse, and a mispredicting resolve flushes every younger entry.
module branch_resolve_queue
  import branch_resolve_queue_pkg::*;
#(
  parameter int unsigned N     = BrqN,
  parameter int unsigned DEPTH = BrqDepth,
  localparam int unsigned CW   = $clog2(DEPTH + 1),
  localparam int unsigned PW   = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          areset_n,
  input  logic          pred_valid,
  input  logic [N-1:0]  pred_pc,
  input  logic          pred_taken,
  input  logic [N-1:0]  pred_history,
  output logic          pred_ready,
  input  logic          res_valid,
  input  logic          res_taken,
  output logic          res_ready,
  output logic          train_valid,
  output logic          train_taken,
  output logic          train_mispredicted,
  output logic [N-1:0]  train_history,
  output logic [N-1:0]  train_pc,
  output logic [CW-1:0] count,
  output logic          err_overflow,
  output logic          err_underflow
);

  localparam logic [CW-1:0] CountFull = CW'(DEPTH);

  brq_entry_t          mem_q [DEPTH];
  logic [PW-1:0]       head_q, head_d;
  logic [PW-1:0]       tail_q, tail_d;
  logic [CW-1:0]       count_q, count_d;
  logic                train_valid_q, train_taken_q, train_mis_q;
  logic [N-1:0]        train_history_q, train_pc_q;
  logic                err_ovf_q, err_udf_q;

  logic       cap, res, mispred, flush;
  brq_entry_t head_entry, new_entry;

  assign pred_ready = (count_q != CountFull);
  assign res_ready  = (count_q != '0);

  assign cap        = pred_valid && pred_ready;
  assign res        = res_valid && res_ready;
  assign head_entry = mem_q[head_q];
  assign mispred    = head_entry.taken ^ res_taken;
  assign flush      = res && mispred;

  always_comb begin
    new_entry         = '0;
    new_entry.pc      = pred_pc;
    new_entry.taken   = pred_taken;
    new_entry.history = pred_history;
  end

  always_comb begin
    head_d  = head_q;
    tail_d  = tail_q;
    count_d = count_q;
    if (flush) begin
      // A same-cycle capture is younger than the mispredicted branch, so it dies too.
      head_d  = '0;
      tail_d  = '0;
      count_d = '0;
    end else begin
      if (cap) tail_d = tail_q + PW'(1);
      if (res) head_d = head_q + PW'(1);
      count_d = count_q + CW'(cap) - CW'(res);
    end
  end

  always_ff @(posedge clk or negedge areset_n) begin
    if (!areset_n) begin
      head_q          <= '0;
      tail_q          <= '0;
      count_q         <= '0;
      train_valid_q   <= 1'b0;
      train_taken_q   <= 1'b0;
      train_mis_q     <= 1'b0;
      train_history_q <= '0;
      train_pc_q      <= '0;
      err_ovf_q       <= 1'b0;
      err_udf_q       <= 1'b0;
    end else begin
      head_q        <= head_d;
      tail_q        <= tail_d;
      count_q       <= count_d;
      train_valid_q <= res;
      if (res) begin
        train_taken_q   <= res_taken;
        train_mis_q     <= mispred;
        train_history_q <= head_entry.history;
        train_pc_q      <= head_entry.pc;
      end
      if (pred_valid && !pred_ready) err_ovf_q <= 1'b1;
      if (res_valid && !res_ready)   err_udf_q <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (cap && !flush) mem_q[tail_q] <= new_entry;
  end

  assign train_valid        = train_valid_q;
  assign train_taken        = train_taken_q;
  assign train_mispredicted = train_mis_q;
  assign train_history      = train_history_q;
  assign train_pc           = train_pc_q;
  assign count              = count_q;
  assign err_overflow       = err_ovf_q;
  assign err_underflow      = err_udf_q;

endmodule

// File: tb/tb_branch_resolve_queue.sv
// Randomised and directed bench: a queue-based reference model feeds a scoreboard
// that a negedge monitor drains whenever the DUT presents a training pulse.
module tb_branch_resolve_queue;

  localparam int unsigned N     = 7;
  localparam int unsigned DEPTH = 8;
  localparam int unsigned CW    = $clog2(DEPTH + 1);

  typedef struct {
    logic [N-1:0] pc;
    logic         taken;
    logic [N-1:0] hist;
  } ent_t;

  typedef struct {
    logic [N-1:0] pc;
    logic [N-1:0] hist;
    logic         taken;
    logic         mis;
  } trn_t;

  logic          clk = 1'b0;
  logic          areset_n = 1'b0;
  logic          pv = 1'b0, pt = 1'b0, rv = 1'b0, rt = 1'b0;
  logic [N-1:0]  ppc = '0, ph = '0;
  logic          pred_ready, res_ready, train_valid, train_taken, train_mis;
  logic [N-1:0]  train_history, train_pc;
  logic [CW-1:0] count;
  logic          err_overflow, err_underflow;

  branch_resolve_queue #(.N(N), .DEPTH(DEPTH)) dut (
    .clk                (clk),
    .areset_n           (areset_n),
    .pred_valid         (pv),
    .pred_pc            (ppc),
    .pred_taken         (pt),
    .pred_history       (ph),
    .pred_ready         (pred_ready),
    .res_valid          (rv),
    .res_taken          (rt),
    .res_ready          (res_ready),
    .train_valid        (train_valid),
    .train_taken        (train_taken),
    .train_mispredicted (train_mis),
    .train_history      (train_history),
    .train_pc           (train_pc),
    .count              (count),
    .err_overflow       (err_overflow),
    .err_underflow      (err_underflow)
  );

  always #5 clk = ~clk;

  int   vectors = 0;
  int   errors  = 0;
  ent_t mq[$];
  trn_t exp_q[$];
  trn_t last;
  logic m_ovf = 1'b0, m_udf = 1'b0;
  logic mon_en = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: the queue's architectural effect of the inputs sampled at this edge.
  task automatic model_step();
    logic full, empty, flush;
    ent_t e;
    trn_t t;
    full  = (mq.size() == DEPTH);
    empty = (mq.size() == 0);
    flush = 1'b0;
    if (pv && full) m_ovf = 1'b1;
    if (rv && empty) m_udf = 1'b1;
    if (rv && !empty) begin
      e       = mq.pop_front();
      t.pc    = e.pc;
      t.hist  = e.hist;
      t.taken = rt;
      t.mis   = (e.taken != rt);
      exp_q.push_back(t);
      flush   = t.mis;
    end
    if (flush) mq.delete();
    else if (pv && !full) begin
      e.pc = ppc; e.taken = pt; e.hist = ph;
      mq.push_back(e);
    end
  endtask

  task automatic model_reset();
    mq.delete();
    exp_q.delete();
    m_ovf = 1'b0;
    m_udf = 1'b0;
    last  = '{pc: '0, hist: '0, taken: 1'b0, mis: 1'b0};
  endtask

  // Called at posedge+1; applies one cycle of stimulus and returns at the next posedge+1.
  task automatic drive(input logic p_v, input logic [N-1:0] p_pc, input logic p_t,
                       input logic [N-1:0] p_h, input logic r_v, input logic r_t);
    pv = p_v; ppc = p_pc; pt = p_t; ph = p_h; rv = r_v; rt = r_t;
    @(posedge clk);
    model_step();
    #1;
    pv = 1'b0; rv = 1'b0;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) drive(1'b0, '0, 1'b0, '0, 1'b0, 1'b0);
  endtask

  task automatic capture(input logic [N-1:0] pc, input logic t, input logic [N-1:0] h);
    drive(1'b1, pc, t, h, 1'b0, 1'b0);
  endtask

  task automatic resolve(input logic t);
    drive(1'b0, '0, 1'b0, '0, 1'b1, t);
  endtask

  task automatic check_reset_state(input string tag);
    chk({tag, ".count"}, 32'(count), 0);
    chk({tag, ".train_valid"}, 32'(train_valid), 0);
    chk({tag, ".train_fields"}, {train_pc, train_history, train_taken, train_mis}, 0);
    chk({tag, ".pred_ready"}, 32'(pred_ready), 1);
    chk({tag, ".res_ready"}, 32'(res_ready), 0);
    chk({tag, ".err"}, {err_overflow, err_underflow}, 0);
  endtask

  always @(negedge clk) begin
    if (mon_en && areset_n) begin
      chk("count", 32'(count), mq.size());
      chk("pred_ready", 32'(pred_ready), 32'(mq.size() != DEPTH));
      chk("res_ready", 32'(res_ready), 32'(mq.size() != 0));
      chk("err", {err_overflow, err_underflow}, {m_ovf, m_udf});
      if (train_valid) begin
        if (exp_q.size() == 0) begin
          chk("unexpected_train_valid", 32'(train_valid), 0);
        end else begin
          last = exp_q.pop_front();
        end
      end else begin
        chk("missing_train_pulse", exp_q.size(), 0);
        exp_q.delete();
      end
      chk("train_pc", 32'(train_pc), 32'(last.pc));
      chk("train_history", 32'(train_history), 32'(last.hist));
      chk("train_taken", 32'(train_taken), 32'(last.taken));
      chk("train_mis", 32'(train_mis), 32'(last.mis));
    end
  end

  initial begin
    logic [N-1:0] pc, h;
    logic t;
    model_reset();
    #2;
    check_reset_state("por");
    @(posedge clk);
    #1;
    areset_n = 1'b1;
    mon_en   = 1'b1;

    // Basic capture, resolve two cycles later.
    capture(7'h12, 1'b1, 7'h05);
    idle(1);
    resolve(1'b1);
    idle(2);

    // Fill, overflow, drain in order.
    for (int i = 0; i < DEPTH; i++) capture(7'(8'h20 + i), 1'b1, 7'(i));
    capture(7'h7f, 1'b0, 7'h7f);
    for (int i = 0; i < DEPTH; i++) resolve(1'b1);
    idle(1);

    // Mispredict flush discards younger entries.
    capture(7'h01, 1'b1, 7'h11);
    capture(7'h02, 1'b1, 7'h12);
    capture(7'h03, 1'b1, 7'h13);
    resolve(1'b0);
    idle(2);

    // Simultaneous capture + correct resolve, then + mispredicting resolve.
    for (int i = 0; i < 3; i++) capture(7'(8'h40 + i), 1'b0, 7'(i));
    drive(1'b1, 7'h50, 1'b1, 7'h50, 1'b1, 1'b0);
    drive(1'b1, 7'h51, 1'b0, 7'h51, 1'b1, 1'b1);
    idle(2);

    // Underflow on empty, then reset in mid-flight at count 5.
    resolve(1'b1);
    idle(1);
    for (int i = 0; i < 5; i++) capture(7'(8'h60 + i), 1'b1, 7'(i));
    areset_n = 1'b0;
    #1;
    check_reset_state("mid_reset");
    model_reset();
    @(posedge clk);
    #1;
    areset_n = 1'b1;
    idle(1);

    // Pointer wrap: 20 capture/resolve pairs with a few entries in flight.
    for (int i = 0; i < 3; i++) capture(7'(8'h70 + i), 1'b0, 7'(i));
    for (int i = 0; i < 20; i++) drive(1'b1, 7'(i), 1'b0, 7'(i + 3), 1'b1, 1'b0);
    idle(1);

    // Random traffic; resolves usually agree with the stored prediction.
    for (int i = 0; i < 400; i++) begin
      pc = 7'($urandom);
      h  = 7'($urandom);
      t  = 1'($urandom);
      rt = 1'($urandom);
      if (mq.size() != 0 && $urandom_range(0, 99) < 85) rt = mq[0].taken;
      drive(1'($urandom_range(0, 99) < 60), pc, t, h, 1'($urandom_range(0, 99) < 45), rt);
    end
    idle(2);

    mon_en = 1'b0;
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule

// File: doc/branch_resolve_queue.md
BRANCH_RESOLVE_QUEUE -- requirements
Module: branch_resolve_queue

Interface
REQ-001 Parameter N, default 7: PC and global-history width.
REQ-002 Parameter DEPTH, default 8: in-flight branch capacity, a power of two >= 2.
REQ-003 clk  in  1  sole clock; all state updates on its rising edge.
REQ-004 areset_n  in  1  reset, asynchronous and active-low.
REQ-005 pred_valid  in  1  predictor issued a prediction this cycle; capture request.
REQ-006 pred_pc  in  N  PC of the predicted branch.
REQ-007 pred_taken  in  1  predicted direction.
REQ-008 pred_history  in  N  global history used for the prediction.
REQ-009 pred_ready  out  1  queue can accept a capture (not full).
REQ-010 res_valid  in  1  oldest outstanding branch resolved this cycle.
REQ-011 res_taken  in  1  actual direction of the oldest branch.
REQ-012 res_ready  out  1  queue holds at least one entry (not empty).
REQ-013 train_valid  out  1  one-cycle training pulse to the predictor.
REQ-014 train_taken  out  1  actual outcome.
REQ-015 train_mispredicted  out  1  stored prediction differed from the actual outcome.
REQ-016 train_history  out  N  history stored with the resolved entry.
REQ-017 train_pc  out  N  PC stored with the resolved entry.
REQ-018 count  out  $clog2(DEPTH+1)  current occupancy.
REQ-019 err_overflow  out  1  sticky flag: capture attempted while full.
REQ-020 err_underflow  out  1  sticky flag: resolve attempted while empty.

Function
REQ-021 Capture: pred_valid && pred_ready writes {pc, taken, history} at the tail; occupancy +1 next cycle.
REQ-022 Resolve: res_valid && res_ready pops the head, in order; occupancy -1 next cycle.
REQ-023 Train outputs are registered: the cycle after an accepted resolve, train_valid=1 and the train_* fields are driven from the popped entry plus res_taken.
REQ-024 train_mispredicted = stored pred_taken XOR res_taken.
REQ-025 train_valid is 0 in every cycle not following an accepted resolve; train_* data are held at their last value when train_valid=0.
REQ-026 Mispredict flush: an accepted resolve with a mispredict empties the queue next cycle (count=0), discarding all younger entries.
REQ-027 A capture in the same cycle as a mispredicting resolve is also discarded.
REQ-028 A capture and a non-mispredicting resolve in the same cycle are both performed; count is unchanged.
REQ-029 pred_ready = (count != DEPTH) and res_ready = (count != 0), both combinational from registered state; there is no same-cycle bypass from capture to resolve.
REQ-030 Capture while full: data is dropped, state is unchanged, and err_overflow is set.
REQ-031 Resolve while empty: ignored, train_valid stays 0, and err_underflow is set.
REQ-032 Head and tail pointers wrap modulo DEPTH; count saturates neither above DEPTH nor below 0.
REQ-033 Error flags clear only on reset.

Reset
REQ-034 While areset_n=0: count=0, pointers=0, train_valid=0, train_taken=0, train_mispredicted=0, train_history=0, train_pc=0, err flags=0, pred_ready=1, res_ready=0.
REQ-035 Reset asserted mid-operation discards all entries immediately; no training pulse is emitted for them.
REQ-036 Storage array contents need no reset.

Structure
REQ-037 A shared package holds N, DEPTH, and the entry typedef {pc[N], taken, history[N]}.
REQ-038 Single module; storage, pointers and output register are inline, with no sub-module.

Verification
REQ-039 Reset then capture pc=0x12/taken=1/hist=0x05 and resolve taken=1 two cycles later -> next cycle train_valid=1, pc=0x12, hist=0x05, taken=1, mispredicted=0.
REQ-040 Capture 8 entries -> pred_ready=0 and count=8; a 9th capture -> err_overflow=1, count=8; 8 correct resolves -> pcs emitted in capture order.
REQ-041 Capture pc 0x01,0x02,0x03 (all taken=1); resolve first with taken=0 -> train_mispredicted=1, pc=0x01; count=0 next cycle; no pulses for 0x02/0x03.
REQ-042 At count=3, simultaneous capture plus correct resolve -> count stays 3; the same cycle with a mispredicting resolve -> count=0.
REQ-043 Resolve at count=0 -> no train pulse and err_underflow=1; assert areset_n=0 at count=5 -> count=0, train_valid=0 immediately.
REQ-044 Run 20 capture/resolve pairs through DEPTH=8 -> pointer wrap keeps FIFO order intact.
